// File: rtl/i2c_slave_responder_if.sv
// Bus lines and byte handshakes between the I2C target and its user logic.
// The slave modport is the responder's view; master is the opposite side.
interface i2c_slave_responder_if #(
   parameter int unsigned DW = 8
);
   logic          scl_i;
   logic          sda_i;
   logic          scl_o;
   logic          sda_o;
   logic [DW-1:0] rx_data_o;
   logic          rx_valid_o;
   logic [DW-1:0] tx_data_i;
   logic          tx_valid_i;
   logic          tx_ready_o;
   logic          rw_o;
   logic          start_o;
   logic          stop_o;
   logic          nack_o;
   logic          busy_o;

   modport slave (
      input  scl_i, sda_i, tx_data_i, tx_valid_i,
      output scl_o, sda_o, rx_data_o, rx_valid_o, tx_ready_o,
             rw_o, start_o, stop_o, nack_o, busy_o
   );

   modport master (
      output scl_i, sda_i, tx_data_i, tx_valid_i,
      input  scl_o, sda_o, rx_data_o, rx_valid_o, tx_ready_o,
             rw_o, start_o, stop_o, nack_o, busy_o
   );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA decode, fixed-address match, byte receive,
// and byte transmit with SCL stretching until read data is handed over.
module i2c_slave_responder #(
   parameter int unsigned               I2C_ADDR_WIDTH = 7,
   parameter int unsigned               I2C_DATA_WIDTH = 8,
   parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
   parameter int unsigned               SYNC_STAGES    = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   i2c_slave_responder_if.slave bus
);
   localparam int unsigned DW   = I2C_DATA_WIDTH;
   localparam logic [3:0]  FULL = 4'(DW);
   localparam logic [3:0]  LAST = 4'(DW - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_BYTE, ST_RX_ACK,
      ST_TX_WAIT, ST_TX_SETUP, ST_TX_BYTE, ST_TX_ACK
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [DW-2:0]          shift_q, shift_d;
   logic                   phase_q, phase_d;
   logic [1:0]             setup_cnt_q, setup_cnt_d;
   logic [DW-1:0]          rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   tx_ready_q, tx_ready_d;
   logic                   rw_q, rw_d;
   logic                   busy_q, busy_d;
   logic                   start_q, start_d;
   logic                   stop_q, stop_d;
   logic                   nack_q, nack_d;
   logic                   scl_q, scl_d;
   logic                   sda_q, sda_d;

   logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, bit_last, addr_match;
   logic [DW-1:0] byte_in;

   assign scl_s      = scl_sync_q[SYNC_STAGES-1];
   assign sda_s      = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise   = scl_s & ~scl_prev_q;
   assign scl_fall   = ~scl_s & scl_prev_q;
   assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign byte_in    = {shift_q, sda_s};
   assign bit_last   = scl_rise & (bit_cnt_q == LAST);
   assign addr_match = (byte_in[DW-1:1] == SLAVE_ADDR);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         phase_q     <= 1'b0;
         setup_cnt_q <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_ready_q  <= 1'b0;
         rw_q        <= 1'b0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         nack_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
      end else begin
         scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
         sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
         scl_prev_q  <= scl_s;
         sda_prev_q  <= sda_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         phase_q     <= phase_d;
         setup_cnt_q <= setup_cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_ready_q  <= tx_ready_d;
         rw_q        <= rw_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         nack_q      <= nack_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
      end
   end

   // START/STOP take priority over any SCL edge seen in the same cycle.
   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = ST_IDLE;
      end else if (start_det) begin
         state_d = ST_ADDR;
      end else begin
         case (state_q)
            ST_ADDR:     if (bit_last) state_d = addr_match ? ST_ADDR_ACK : ST_IDLE;
            ST_ADDR_ACK: if (scl_fall && phase_q) state_d = rw_q ? ST_TX_WAIT : ST_RX_BYTE;
            ST_RX_BYTE:  if (bit_last) state_d = ST_RX_ACK;
            ST_RX_ACK:   if (scl_fall && phase_q) state_d = ST_RX_BYTE;
            ST_TX_WAIT:  if (bus.tx_valid_i && tx_ready_q) state_d = ST_TX_SETUP;
            ST_TX_SETUP: if (setup_cnt_q == 2'd0) state_d = ST_TX_BYTE;
            ST_TX_BYTE:  if (scl_fall && (bit_cnt_q == FULL)) state_d = ST_TX_ACK;
            ST_TX_ACK: begin
               if (scl_rise && sda_s)        state_d = ST_IDLE;
               else if (scl_fall && phase_q) state_d = ST_TX_WAIT;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // phase_q marks the second falling edge of an ACK slot (drive, then release).
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      phase_d     = phase_q;
      setup_cnt_d = setup_cnt_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_ready_d  = tx_ready_q;
      rw_d        = rw_q;
      busy_d      = busy_q;
      start_d     = 1'b0;
      stop_d      = 1'b0;
      nack_d      = 1'b0;
      scl_d       = scl_q;
      sda_d       = sda_q;
      if (stop_det) begin
         stop_d     = 1'b1;
         busy_d     = 1'b0;
         tx_ready_d = 1'b0;
         phase_d    = 1'b0;
         scl_d      = 1'b1;
         sda_d      = 1'b1;
      end else if (start_det) begin
         start_d    = 1'b1;
         bit_cnt_d  = '0;
         tx_ready_d = 1'b0;
         phase_d    = 1'b0;
         scl_d      = 1'b1;
         sda_d      = 1'b1;
      end else begin
         case (state_q)
            ST_ADDR, ST_RX_BYTE: begin
               if (scl_rise) begin
                  shift_d = byte_in[DW-2:0];
                  if (bit_cnt_q != FULL) bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_last) begin
                     phase_d = 1'b0;
                     if (state_q == ST_ADDR) begin
                        busy_d = addr_match;
                        if (addr_match) rw_d = sda_s;
                     end else begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                     end
                  end
               end
            end
            ST_ADDR_ACK, ST_RX_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_d   = 1'b0;
                     phase_d = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     bit_cnt_d = '0;
                     if ((state_q == ST_ADDR_ACK) && rw_q) begin
                        scl_d      = 1'b0;
                        tx_ready_d = 1'b1;
                     end else begin
                        sda_d = 1'b1;
                     end
                  end
               end
            end
            ST_TX_WAIT: begin
               if (bus.tx_valid_i && tx_ready_q) begin
                  shift_d     = bus.tx_data_i[DW-2:0];
                  sda_d       = bus.tx_data_i[DW-1];
                  tx_ready_d  = 1'b0;
                  setup_cnt_d = 2'd1;
               end
            end
            ST_TX_SETUP: begin
               if (setup_cnt_q == 2'd0) begin
                  scl_d     = 1'b1;
                  bit_cnt_d = 4'd1;
               end else begin
                  setup_cnt_d = setup_cnt_q - 2'd1;
               end
            end
            ST_TX_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_q == FULL) begin
                     sda_d = 1'b1;
                  end else begin
                     sda_d     = shift_q[DW-2];
                     shift_d   = shift_q << 1;
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_TX_ACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     nack_d = 1'b1;
                     scl_d  = 1'b1;
                     sda_d  = 1'b1;
                  end else begin
                     phase_d = 1'b1;
                  end
               end else if (scl_fall && phase_q) begin
                  phase_d    = 1'b0;
                  scl_d      = 1'b0;
                  tx_ready_d = 1'b1;
               end
            end
            default: begin
               scl_d = 1'b1;
               sda_d = 1'b1;
            end
         endcase
      end
   end

   assign bus.scl_o      = scl_q;
   assign bus.sda_o      = sda_q;
   assign bus.rx_data_o  = rx_data_q;
   assign bus.rx_valid_o = rx_valid_q;
   assign bus.tx_ready_o = tx_ready_q;
   assign bus.rw_o       = rw_q;
   assign bus.start_o    = start_q;
   assign bus.stop_o     = stop_q;
   assign bus.nack_o     = nack_q;
   assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-level I2C master on wired-AND lines,
// a tx data provider, and scoreboards for received and transmitted bytes.
module tb_i2c_slave_responder;
   localparam int unsigned Q   = 8;
   localparam int unsigned TMO = 3000;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   int tests = 0;
   int fails = 0;

   int start_cnt = 0, stop_cnt = 0, nack_cnt = 0, hs_cnt = 0, busy_cnt = 0, sda_low_cnt = 0;
   logic ready_prev = 1'b0;
   logic [7:0] rx_got_q[$];
   logic [7:0] exp_rx_q[$];
   logic [7:0] exp_tx_q[$];

   i2c_slave_responder_if #(.DW(8)) bus ();

   assign bus.scl_i = scl_m & bus.scl_o;
   assign bus.sda_i = sda_m & bus.sda_o;

   i2c_slave_responder #(
      .I2C_ADDR_WIDTH(7),
      .I2C_DATA_WIDTH(8),
      .SLAVE_ADDR    (7'h22),
      .SYNC_STAGES   (2)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_i) begin
         if (bus.start_o) start_cnt++;
         if (bus.stop_o) stop_cnt++;
         if (bus.nack_o) nack_cnt++;
         if (bus.busy_o) busy_cnt++;
         if (!bus.sda_o) sda_low_cnt++;
         if (ready_prev && !bus.tx_ready_o) hs_cnt++;
         if (bus.rx_valid_o) rx_got_q.push_back(bus.rx_data_o);
      end
      ready_prev = bus.tx_ready_o;
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b, output logic s);
      int unsigned n;
      n = 0;
      sda_m = b;
      wait_q();
      scl_m = 1'b1;
      while (bus.scl_i !== 1'b1 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      if (bus.scl_i !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL scl_release: scl=%b required 1", bus.scl_i);
      end
      wait_q();
      s = bus.sda_i;
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] d);
      logic s;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, s);
         d = {d[6:0], s};
      end
      clock_bit(ack_bit, s);
   endtask

   task automatic provide_tx(input logic [7:0] d, input int unsigned delay);
      int unsigned n;
      n = 0;
      while (bus.tx_ready_o !== 1'b1 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (bus.tx_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL tx_ready_wait: tx_ready=%b required 1", bus.tx_ready_o);
      end
      repeat (delay) @(negedge clk);
      tests++;
      if ({bus.scl_o, bus.tx_ready_o} !== 2'b01) begin
         fails++;
         $display("FAIL stretch_hold: {scl_o,tx_ready}=%b required 01", {bus.scl_o, bus.tx_ready_o});
      end
      exp_tx_q.push_back(d);
      bus.tx_data_i = d;
      bus.tx_valid_i = 1'b1;
      @(negedge clk);
      bus.tx_valid_i = 1'b0;
      tests++;
      if ({bus.tx_ready_o, bus.scl_o, bus.sda_o} !== {1'b0, 1'b0, d[7]}) begin
         fails++;
         $display("FAIL handshake: {ready,scl,sda}=%b required %b",
                  {bus.tx_ready_o, bus.scl_o, bus.sda_o}, {1'b0, 1'b0, d[7]});
      end
      @(negedge clk);
      tests++;
      if (bus.scl_o !== 1'b0) begin
         fails++;
         $display("FAIL setup_hold: scl_o=%b required 0", bus.scl_o);
      end
      @(negedge clk);
      tests++;
      if (bus.scl_o !== 1'b1) begin
         fails++;
         $display("FAIL setup_release: scl_o=%b required 1", bus.scl_o);
      end
   endtask

   task automatic check_rx_scoreboard(input string name);
      logic [7:0] e, g;
      while (exp_rx_q.size() > 0) begin
         e = exp_rx_q.pop_front();
         tests++;
         if (rx_got_q.size() == 0) begin
            fails++;
            $display("FAIL %s_rx: no byte received, required %h", name, e);
         end else begin
            g = rx_got_q.pop_front();
            if (g !== e) begin
               fails++;
               $display("FAIL %s_rx: rx_data=%h required %h", name, g, e);
            end
         end
      end
      tests++;
      if (rx_got_q.size() != 0) begin
         fails++;
         $display("FAIL %s_rx_extra: %0d unexpected bytes, required 0", name, rx_got_q.size());
         rx_got_q.delete();
      end
   endtask

   task automatic check_tx_byte(input string name, input logic [7:0] got);
      logic [7:0] e;
      tests++;
      if (exp_tx_q.size() == 0) begin
         fails++;
         $display("FAIL %s_tx: read %h with no byte provided", name, got);
      end else begin
         e = exp_tx_q.pop_front();
         if (got !== e) begin
            fails++;
            $display("FAIL %s_tx: read %h required %h", name, got, e);
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      logic [16:0] got;
      got = {bus.scl_o, bus.sda_o, bus.rx_data_o, bus.rx_valid_o, bus.tx_ready_o, bus.rw_o,
             bus.start_o, bus.stop_o, bus.nack_o, bus.busy_o};
      tests++;
      if (got !== {2'b11, 8'h00, 7'b0}) begin
         fails++;
         $display("FAIL %s: outputs=%b required %b", name, got, {2'b11, 8'h00, 7'b0});
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst_i = 1'b1;
      repeat (5) @(negedge clk);
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic test_write();
      logic a0, a1;
      int s0, p0;
      s0 = start_cnt; p0 = stop_cnt;
      i2c_start();
      write_byte(8'h44, a0);
      exp_rx_q.push_back(8'h78);
      write_byte(8'h78, a1);
      tests++;
      if ({a0, a1} !== 2'b00) begin
         fails++;
         $display("FAIL write_ack: acks=%b required 00", {a0, a1});
      end
      tests++;
      if ({bus.rw_o, bus.busy_o} !== 2'b01) begin
         fails++;
         $display("FAIL write_rw_busy: {rw,busy}=%b required 01", {bus.rw_o, bus.busy_o});
      end
      i2c_stop();
      check_rx_scoreboard("write");
      tests++;
      if ({start_cnt - s0, stop_cnt - p0} !== {32'd1, 32'd1}) begin
         fails++;
         $display("FAIL write_events: start=%0d stop=%0d required 1 1", start_cnt - s0, stop_cnt - p0);
      end
      tests++;
      if (bus.busy_o !== 1'b0) begin
         fails++;
         $display("FAIL write_busy_end: busy=%b required 0", bus.busy_o);
      end
   endtask

   task automatic test_addr_mismatch();
      logic a0, a1;
      int b0, l0;
      b0 = busy_cnt; l0 = sda_low_cnt;
      i2c_start();
      write_byte(8'h46, a0);
      write_byte(8'h12, a1);
      i2c_stop();
      tests++;
      if ({a0, a1} !== 2'b11) begin
         fails++;
         $display("FAIL mismatch_ack: acks=%b required 11", {a0, a1});
      end
      tests++;
      if (sda_low_cnt != l0 || busy_cnt != b0) begin
         fails++;
         $display("FAIL mismatch_quiet: sda_low=%0d busy=%0d cycles required 0 0",
                  sda_low_cnt - l0, busy_cnt - b0);
      end
      check_rx_scoreboard("mismatch");
   endtask

   task automatic test_read_stretch();
      logic a;
      logic [7:0] d;
      int n0;
      n0 = nack_cnt;
      i2c_start();
      write_byte(8'h45, a);
      tests++;
      if ({a, bus.rw_o} !== 2'b01) begin
         fails++;
         $display("FAIL read_addr: {ack,rw}=%b required 01", {a, bus.rw_o});
      end
      fork
         provide_tx(8'hA5, 50);
         read_byte(1'b1, d);
      join
      check_tx_byte("read_stretch", d);
      repeat (2) @(negedge clk);
      tests++;
      if ({nack_cnt - n0, bus.scl_o, bus.sda_o} !== {32'd1, 2'b11}) begin
         fails++;
         $display("FAIL read_nack: nacks=%0d scl=%b sda=%b required 1 1 1",
                  nack_cnt - n0, bus.scl_o, bus.sda_o);
      end
      i2c_stop();
   endtask

   task automatic test_multi_read();
      logic a;
      logic [7:0] d0, d1;
      int n0, h0;
      n0 = nack_cnt; h0 = hs_cnt;
      i2c_start();
      write_byte(8'h45, a);
      fork
         provide_tx(8'h3C, 3);
         read_byte(1'b0, d0);
      join
      check_tx_byte("multi0", d0);
      fork
         provide_tx(8'hC3, 7);
         read_byte(1'b1, d1);
      join
      check_tx_byte("multi1", d1);
      i2c_stop();
      tests++;
      if ({hs_cnt - h0, nack_cnt - n0} !== {32'd2, 32'd1}) begin
         fails++;
         $display("FAIL multi_counts: handshakes=%0d nacks=%0d required 2 1", hs_cnt - h0, nack_cnt - n0);
      end
   endtask

   task automatic test_repeated_start();
      logic a0, a1, a2;
      logic [7:0] d;
      int s0;
      s0 = start_cnt;
      i2c_start();
      write_byte(8'h44, a0);
      exp_rx_q.push_back(8'h11);
      write_byte(8'h11, a1);
      tests++;
      if (bus.rw_o !== 1'b0) begin
         fails++;
         $display("FAIL rs_rw_write: rw=%b required 0", bus.rw_o);
      end
      i2c_start();
      write_byte(8'h45, a2);
      tests++;
      if ({a0, a1, a2, bus.rw_o} !== 4'b0001) begin
         fails++;
         $display("FAIL rs_rw_read: {acks,rw}=%b required 0001", {a0, a1, a2, bus.rw_o});
      end
      fork
         provide_tx(8'h5A, 4);
         read_byte(1'b1, d);
      join
      check_tx_byte("rs", d);
      i2c_stop();
      check_rx_scoreboard("rs");
      tests++;
      if (bus.rx_data_o !== 8'h11 || start_cnt - s0 != 2) begin
         fails++;
         $display("FAIL rs_events: rx_data=%h starts=%0d required 11 2", bus.rx_data_o, start_cnt - s0);
      end
   endtask

   task automatic test_abort();
      logic a, s;
      int p0;
      int unsigned n;
      p0 = stop_cnt;
      i2c_start();
      write_byte(8'h44, a);
      clock_bit(1'b1, s);
      clock_bit(1'b0, s);
      clock_bit(1'b1, s);
      clock_bit(1'b1, s);
      i2c_stop();
      check_rx_scoreboard("abort");
      tests++;
      if ({stop_cnt - p0, bus.busy_o} !== {32'd1, 1'b0}) begin
         fails++;
         $display("FAIL abort_stop: stops=%0d busy=%b required 1 0", stop_cnt - p0, bus.busy_o);
      end
      i2c_start();
      for (int i = 7; i >= 0; i--) clock_bit(i == 6 || i == 2, s);
      n = 0;
      while (bus.sda_o !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (bus.sda_o !== 1'b0) begin
         fails++;
         $display("FAIL ack_slot_drive: sda_o=%b required 0", bus.sda_o);
      end
      rst_i = 1'b0;
      #1;
      tests++;
      if ({bus.scl_o, bus.sda_o} !== 2'b11) begin
         fails++;
         $display("FAIL async_release: {scl,sda}=%b required 11", {bus.scl_o, bus.sda_o});
      end
      @(negedge clk);
      check_reset_outputs("abort_reset");
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      rst_i = 1'b1;
      wait_q();
   endtask

   initial begin
      bus.tx_data_i = '0;
      bus.tx_valid_i = 1'b0;
      test_reset();
      test_write();
      test_addr_mismatch();
      test_read_stretch();
      test_multi_read();
      test_repeated_start();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end
endmodule
